// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle decode/issue controller driving the regfile, operand regs and ALU.
// Optional ALU_SEQ_ILLEGAL_TRAP_EN: undecoded instructions lock into TRAP (illegal = 1) until reset.
module alu_op_sequencer #(
  parameter int IW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] instr,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    ALUop,
  output logic          loadc,
  output logic          loads,
  output logic          vsel,
  output logic [IW-1:0] sximm8,
  output logic          done
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic          illegal
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_RD_A   = 3'd2,
    S_RD_B   = 3'd3,
    S_EXEC   = 3'd4,
    S_FLAGS  = 3'd5,
    S_WB     = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  function automatic logic f_mov_imm(input logic [IW-1:0] ir);
    return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b10);
  endfunction

  function automatic logic f_mov_reg(input logic [IW-1:0] ir);
    return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b00);
  endfunction

  function automatic logic f_alu(input logic [IW-1:0] ir);
    return (ir[15:13] == 3'b101);
  endfunction

  function automatic logic f_cmp(input logic [IW-1:0] ir);
    return (ir[15:13] == 3'b101) && (ir[12:11] == 2'b01);
  endfunction

  function automatic logic f_legal(input logic [IW-1:0] ir);
    return f_mov_imm(ir) || f_mov_reg(ir) || f_alu(ir);
  endfunction

  function automatic logic [RW-1:0] f_rn(input logic [IW-1:0] ir);
    return ir[8 +: RW];
  endfunction

  function automatic logic [RW-1:0] f_rd(input logic [IW-1:0] ir);
    return ir[5 +: RW];
  endfunction

  function automatic logic [RW-1:0] f_rm(input logic [IW-1:0] ir);
    return ir[0 +: RW];
  endfunction

  state_t        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          in_ready_q, in_ready_d;
  logic [RW-1:0] readnum_q, readnum_d;
  logic [RW-1:0] writenum_q, writenum_d;
  logic          write_q, write_d;
  logic          loada_q, loada_d;
  logic          loadb_q, loadb_d;
  logic          asel_q, asel_d;
  logic          bsel_q, bsel_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic          loadc_q, loadc_d;
  logic          loads_q, loads_d;
  logic          vsel_q, vsel_d;
  logic          done_q, done_d;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic          illegal_q, illegal_d;
`endif
  logic          accept_s;

  assign accept_s = in_valid && in_ready_q;

  // Next-state and instruction capture
  always_comb begin
    state_d = state_q;
    ir_d    = accept_s ? instr : ir_q;
    case (state_q)
      S_IDLE:   state_d = accept_s ? S_DECODE : S_IDLE;
      S_DECODE: begin
        if (f_mov_imm(ir_q)) begin
          state_d = S_WB;
        end else if (f_mov_reg(ir_q)) begin
          state_d = S_RD_B;
        end else if (f_alu(ir_q)) begin
          state_d = (ir_q[12:11] == 2'b11) ? S_RD_B : S_RD_A;
        end else begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_RD_A:   state_d = S_RD_B;
      S_RD_B:   state_d = S_EXEC;
      S_EXEC:   state_d = f_cmp(ir_q) ? S_IDLE : S_WB;
      S_FLAGS:  state_d = S_IDLE;
      S_WB:     state_d = S_IDLE;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so every control line leaves a flop
  always_comb begin
    in_ready_d = 1'b0;
    readnum_d  = readnum_q;
    writenum_d = writenum_q;
    alu_op_d   = alu_op_q;
    write_d    = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    asel_d     = 1'b0;
    bsel_d     = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    vsel_d     = 1'b0;
    done_d     = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    illegal_d  = 1'b0;
`endif
    case (state_d)
      S_IDLE:   in_ready_d = 1'b1;
      S_DECODE: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        done_d = 1'b0;
`else
        // an undecodable word retires here as a NOP
        done_d = !f_legal(ir_d);
`endif
      end
      S_RD_A: begin
        readnum_d = f_rn(ir_d);
        loada_d   = 1'b1;
      end
      S_RD_B: begin
        readnum_d = f_rm(ir_d);
        loadb_d   = 1'b1;
      end
      S_EXEC: begin
        alu_op_d = f_mov_reg(ir_d) ? 2'b00 : ir_d[12:11];
        asel_d   = f_mov_reg(ir_d);
        loadc_d  = !f_cmp(ir_d);
        loads_d  = f_alu(ir_d);
        done_d   = f_cmp(ir_d);
      end
      S_FLAGS:  loads_d = 1'b1;
      S_WB: begin
        writenum_d = f_mov_imm(ir_d) ? f_rn(ir_d) : f_rd(ir_d);
        vsel_d     = f_mov_imm(ir_d);
        write_d    = 1'b1;
        done_d     = 1'b1;
      end
      S_TRAP: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        illegal_d = 1'b1;
`else
        in_ready_d = 1'b0;
`endif
      end
      default:  in_ready_d = 1'b0;
    endcase
  end

  // State, instruction and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ir_q       <= {IW{1'b0}};
      in_ready_q <= 1'b1;
      readnum_q  <= {RW{1'b0}};
      writenum_q <= {RW{1'b0}};
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      asel_q     <= 1'b0;
      bsel_q     <= 1'b0;
      alu_op_q   <= 2'b00;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      vsel_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      in_ready_q <= in_ready_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      write_q    <= write_d;
      loada_q    <= loada_d;
      loadb_q    <= loadb_d;
      asel_q     <= asel_d;
      bsel_q     <= bsel_d;
      alu_op_q   <= alu_op_d;
      loadc_q    <= loadc_d;
      loads_q    <= loads_d;
      vsel_q     <= vsel_d;
      done_q     <= done_d;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      illegal_q  <= illegal_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign readnum  = readnum_q;
  assign writenum = writenum_q;
  assign write    = write_q;
  assign loada    = loada_q;
  assign loadb    = loadb_q;
  assign asel     = asel_q;
  assign bsel     = bsel_q;
  assign ALUop    = alu_op_q;
  assign loadc    = loadc_q;
  assign loads    = loads_q;
  assign vsel     = vsel_q;
  assign done     = done_q;
  assign sximm8   = {{(IW-8){ir_q[7]}}, ir_q[7:0]};
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign illegal  = illegal_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: per-cycle expected control vectors are queued at issue
// and compared at each falling edge. Honours ALU_SEQ_ILLEGAL_TRAP_EN when defined.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, asel, bsel, loadc, loads, vsel, done;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  always #5 clk = ~clk;

  alu_op_sequencer #(.IW(16), .RW(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .readnum(readnum), .writenum(writenum), .write(write), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .ALUop(ALUop), .loadc(loadc), .loads(loads), .vsel(vsel),
    .sximm8(sximm8), .done(done)
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  typedef struct packed {
    logic        in_ready, loada, loadb, loadc, loads, write, done, asel, bsel, vsel, illegal;
    logic [2:0]  readnum, writenum;
    logic [1:0]  aluop;
    logic [15:0] sximm8;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [2:0]  m_readnum, m_writenum;
  logic [1:0]  m_aluop;
  logic [15:0] m_sximm8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic exp_t base_rec();
    exp_t r;
    r = '0;
    r.readnum  = m_readnum;
    r.writenum = m_writenum;
    r.aluop    = m_aluop;
    r.sximm8   = m_sximm8;
    return r;
  endfunction

  function automatic exp_t idle_rec();
    exp_t r;
    r = base_rec();
    r.in_ready = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_readnum  = 3'd0;
    m_writenum = 3'd0;
    m_aluop    = 2'b00;
    m_sximm8   = 16'h0000;
  endtask

  // Build the expected cycle-by-cycle outputs of one instruction, DECODE up to the IDLE after it
  task automatic push_instr(input logic [15:0] i);
    exp_t       r;
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op;
    opc = i[15:13]; op = i[12:11]; rn = i[10:8]; rd = i[7:5]; rm = i[2:0];
    m_sximm8 = {{8{i[7]}}, i[7:0]};
    r = base_rec();
`ifndef ALU_SEQ_ILLEGAL_TRAP_EN
    r.done = !((opc == 3'b110 && (op == 2'b10 || op == 2'b00)) || opc == 3'b101);
`endif
    exp_q.push_back(r);
    if (opc == 3'b110 && op == 2'b10) begin
      m_writenum = rn;
      r = base_rec(); r.vsel = 1'b1; r.write = 1'b1; r.done = 1'b1; exp_q.push_back(r);
    end else if (opc == 3'b110 && op == 2'b00) begin
      m_readnum = rm;
      r = base_rec(); r.loadb = 1'b1; exp_q.push_back(r);
      m_aluop = 2'b00;
      r = base_rec(); r.asel = 1'b1; r.loadc = 1'b1; exp_q.push_back(r);
      m_writenum = rd;
      r = base_rec(); r.write = 1'b1; r.done = 1'b1; exp_q.push_back(r);
    end else if (opc == 3'b101) begin
      if (op != 2'b11) begin
        m_readnum = rn;
        r = base_rec(); r.loada = 1'b1; exp_q.push_back(r);
      end
      m_readnum = rm;
      r = base_rec(); r.loadb = 1'b1; exp_q.push_back(r);
      m_aluop = op;
      r = base_rec(); r.loads = 1'b1; r.loadc = (op != 2'b01); r.done = (op == 2'b01);
      exp_q.push_back(r);
      if (op != 2'b01) begin
        m_writenum = rd;
        r = base_rec(); r.write = 1'b1; r.done = 1'b1; exp_q.push_back(r);
      end
    end else begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      for (int k = 0; k < 3; k++) begin
        r = base_rec(); r.illegal = 1'b1; exp_q.push_back(r);
      end
      return;
`endif
    end
    exp_q.push_back(idle_rec());
  endtask

  task automatic compare_rec(input exp_t e);
    check("in_ready", in_ready, e.in_ready);
    check("loada", loada, e.loada);
    check("loadb", loadb, e.loadb);
    check("loadc", loadc, e.loadc);
    check("loads", loads, e.loads);
    check("write", write, e.write);
    check("done", done, e.done);
    check("asel", asel, e.asel);
    check("bsel", bsel, e.bsel);
    check("vsel", vsel, e.vsel);
    check("readnum", readnum, e.readnum);
    check("writenum", writenum, e.writenum);
    check("ALUop", ALUop, e.aluop);
    check("sximm8", sximm8, e.sximm8);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    check("illegal", illegal, e.illegal);
`endif
  endtask

  // Pop and compare one record per falling edge; optionally drop in_valid after record drop_at
  task automatic drain(input int drop_at, input int max_n, output int first_done);
    exp_t e;
    int   n;
    n = 0;
    first_done = 0;
    while (exp_q.size() > 0 && (max_n == 0 || n < max_n)) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n++;
      if (done === 1'b1 && first_done == 0) first_done = n;
      compare_rec(e);
      if (n == drop_at) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
    end
  endtask

  task automatic issue(input logic [15:0] i);
    check("accept_ready", in_ready, 1'b1);
    push_instr(i);
    in_valid = 1'b1;
    instr    = i;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    instr    = 16'($urandom);
  endtask

  task automatic run_one(input string tag, input logic [15:0] i, input int lat);
    int fd;
    issue(i);
    drain(0, 0, fd);
    if (lat > 0) check(tag, fd + 1, lat);
  endtask

  task automatic apply_reset();
    int fd;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    model_reset();
    for (int k = 0; k < 3; k++) exp_q.push_back(idle_rec());
    drain(0, 0, fd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int fd, l1;
    reset    = 1'b1;
    in_valid = 1'b0;
    instr    = 16'h0000;
    model_reset();
    apply_reset();

    run_one("lat_mov_imm_neg", 16'hD3FE, 3);  // MOV R3, #-2
    run_one("lat_add", 16'hA140, 6);          // ADD R2, R1, R0
    run_one("lat_cmp", 16'hA900, 5);          // CMP R1, R0
    run_one("lat_mov_reg", 16'hC0A6, 5);      // MOV R5, R6
    run_one("lat_and", 16'hB264, 6);          // AND R3, R2, R4
    run_one("lat_mov_imm_pos", 16'hD705, 3);  // MOV R7, #5

    // Back-to-back MVNs with in_valid held high
    check("b2b_ready", in_ready, 1'b1);
    push_instr(16'hB8C7);
    l1 = exp_q.size();
    push_instr(16'hB822);
    in_valid = 1'b1;
    instr    = 16'hB8C7;
    @(posedge clk);
    #1 instr = 16'hB822;
    drain(l1, 0, fd);

    // Reset while an ADD sits in RD_B
    issue(16'hA140);
    drain(0, 3, fd);
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) exp_q.push_back(idle_rec());
    drain(0, 0, fd);
    run_one("lat_after_reset", 16'hD3FE, 3);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    issue(16'hE123);
    drain(0, 0, fd);
    apply_reset();
    run_one("lat_after_trap", 16'hA140, 6);
`else
    run_one("lat_illegal_111", 16'hE123, 2);
    run_one("lat_illegal_000", 16'h0000, 2);
    run_one("lat_illegal_mov01", 16'hC800, 2);
    run_one("lat_after_nop", 16'hA140, 6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that drives the datapath ALU and the register file. It is the initiator side of the ALU interface.
- Accepts one 16-bit instruction per valid/ready handshake and decodes it into register-file reads and operand loads.
- Issues the 2-bit ALU opcode, then latches the ALU result and flag outputs (Z, N, V).
- Sits between instruction fetch and the datapath (regfile + operand regs A/B + ALU + result reg C + status reg).

Parameters:
- IW, 16, instruction width; the field layout below assumes 16.
- RW, 3, register-number width (8 registers).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction word presented
- in_ready  out  1  sequencer able to accept an instruction
- instr  in  16  instruction word; captured when in_valid && in_ready
- readnum  out  3  register-file read address
- writenum  out  3  register-file write address
- write  out  1  register-file write enable
- loada  out  1  load operand register A from the regfile read data
- loadb  out  1  load operand register B from the regfile read data
- asel  out  1  1 = force the ALU A input to 0
- bsel  out  1  1 = ALU B input = sign-extended imm8
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B
- loadc  out  1  load result register C from the ALU output
- loads  out  1  load status register from the ALU Z/N/V flags
- vsel  out  1  writeback source: 0 = C, 1 = sign-extended imm8
- sximm8  out  16  sign-extended instr[7:0]
- done  out  1  one-cycle pulse on the last cycle of an instruction

Behaviour:
- Instruction fields: opcode = instr[15:13], op = instr[12:11], Rn = instr[10:8], Rd = instr[7:5], Rm = instr[2:0]. All fields are captured into an internal register at accept.
- Reset (any cycle, including mid-instruction): state = IDLE; in_ready = 1. All enables (write, loada, loadb, loadc, loads, done) = 0. readnum, writenum, ALUop, asel, bsel and vsel = 0.
- in_ready = 1 only in IDLE.
- Accept: in_valid && in_ready. The next state is DECODE.
- States:
  - IDLE.
  - DECODE: decode only; no enables asserted.
  - RD_A: readnum = Rn, loada = 1.
  - RD_B: readnum = Rm, loadb = 1.
  - EXEC: ALUop = op, loadc = 1 except for CMP.
  - FLAGS: loads = 1, only for CMP.
  - WB: writenum = Rd, write = 1.
  - Back to IDLE.
- Paths:
  - opcode 110, op 10 (MOV imm): DECODE -> WB with writenum = Rn, vsel = 1, write = 1. Total 3 cycles, accept to done inclusive.
  - opcode 110, op 00 (MOV reg): DECODE -> RD_B -> EXEC (asel = 1, ALUop = 00) -> WB (vsel = 0).
  - opcode 101, op 00/10 (ADD/AND): DECODE -> RD_A -> RD_B -> EXEC -> WB. 6 cycles.
  - opcode 101, op 01 (CMP): DECODE -> RD_A -> RD_B -> EXEC (ALUop = 01, loadc = 0, loads = 1 in the same cycle) -> IDLE. No WB, no register write.
  - opcode 101, op 11 (MVN): DECODE -> RD_B -> EXEC (ALUop = 11) -> WB.
- loads = 1 in every EXEC cycle of an opcode-101 instruction; flags are never updated for MOV. The FLAGS state exists only as a named state for CMP and is merged into EXEC.
- done pulses in the final state (WB, or EXEC for CMP) and never coincides with in_ready.
- Any other opcode/op combination is handled per the optional feature.
- sximm8 is combinational from the latched instr[7:0]. Wrap/overflow is the ALU's concern; the sequencer performs no arithmetic.
- The signals readnum, writenum and ALUop hold their last value outside their active states; only the enables return to 0.

Optional Feature:
- Macro ALU_SEQ_ILLEGAL_TRAP_EN.
- Defined: an undecoded opcode/op moves DECODE -> TRAP. TRAP holds in_ready = 0 and illegal = 1 (an extra 1-bit output port) until reset.
- Not defined: an undecoded instruction completes as a NOP: DECODE -> IDLE with a done pulse and no enables asserted.

Test Plan:
- Reset in the middle of an ADD (during RD_B) -> next cycle in IDLE, in_ready = 1, all enables 0, write never asserted.
- MOV imm: instr = 110_10_011_11111110 (R3 <- -2) -> sximm8 = 16'hFFFE, vsel = 1, writenum = 3, write = 1, done 3 cycles after accept.
- ADD R2 = R1 + R0: instr = 101_00_001_010_00_000 -> readnum 1 with loada, then readnum 0 with loadb, then ALUop = 00 with loadc and loads, then writenum = 2 with write; 6 cycles total.
- CMP R1, R0 -> ALUop = 01, loads = 1, loadc = 0, write never 1, done in EXEC; in_ready returns the next cycle.
- Back-to-back: in_valid held high with two MVN instructions -> second accepted only in IDLE after the first done; no overlap of enables.
- Illegal opcode 111 -> with macro: illegal = 1 and in_ready stuck at 0 until reset; without macro: done pulse, no enables, return to IDLE.
